present_pool_ctrl: RTL and testbench
====================================

Name: present_pool_ctrl

Overview:
Parametrised manager for a pool of NUM_SLOTS falling-present slots in the game engine. It sits between the random present generator and the per-slot present movement/draw units. On a drop request it allocates the lowest free slot, times its lifetime in seconds, and clears it on expiry or on a player/rope collision. Collected presents are reported through a one-per-cycle, lowest-index-first result stream, so simultaneous pickups are never lost.

Parameters:
NUM_SLOTS, 3, number of present slots (1..8)
TYPE_W, 2, width of the present type code
LIFE_SEC, 10, lifetime in sec_tick pulses (1..2^TIMER_W-1)
TIMER_W, 4, width of the per-slot lifetime counter
BLINK_SEC, 3, remaining-seconds threshold for blinking (used only with PRESENT_BLINK_EN)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
drop_req  in  1  one-cycle request to drop a new present
drop_type  in  TYPE_W  type for the requested present, sampled with drop_req
sec_tick  in  1  one-cycle pulse per second
col_player  in  NUM_SLOTS  per-slot player/present collision
col_rope  in  NUM_SLOTS  per-slot rope/present collision
slot_visible  out  NUM_SLOTS  slot drawn on screen
slot_run  out  NUM_SLOTS  high while slot is ACTIVE; low holds the slot's movement unit in reset
drop_ack  out  1  registered pulse: request accepted
drop_slot  out  3  index of the allocated slot, valid with drop_ack
pool_full  out  1  registered: no slot is IDLE
collect_valid  out  1  one-cycle pulse: one collected present reported
collect_type  out  TYPE_W  type of the reported present
collect_slot  out  3  index of the reported slot
expire_pulse  out  1  one-cycle pulse: at least one slot timed out this cycle
col_any  out  1  combinational OR of all col_player and col_rope bits

Behaviour:
- Clock: clk. Reset: resetN, asynchronous, active-low. On reset, every slot is IDLE, every timer = LIFE_SEC, and every type = 0. All outputs are 0, except pool_full = 0 (NUM_SLOTS >= 1).
- Per-slot FSM states:
  - IDLE -> ACTIVE when the slot is allocated: load timer = LIFE_SEC and type = drop_type.
  - ACTIVE -> PENDING on col_player[i] | col_rope[i].
  - ACTIVE -> IDLE on expiry.
  - PENDING -> IDLE when the slot is reported on collect_*.
- Allocation: drop_req picks the lowest-index slot that is IDLE at the current state. A slot freed in the same cycle is not reusable until the next cycle. drop_ack and drop_slot are registered, so they appear 1 cycle after drop_req. If no slot is IDLE, the request is dropped with no ack.
- Timer: in ACTIVE, each sec_tick decrements the timer. A sec_tick with timer == 1 expires the slot, so a slot lives exactly LIFE_SEC ticks. expire_pulse is registered.
- Priority within one slot: a collision beats expiry on the same cycle (the present is collected). Collision bits on IDLE or PENDING slots are ignored.
- Reporting: each cycle, the lowest-index PENDING slot drives collect_valid, collect_type and collect_slot (registered, so one cycle later), then returns to IDLE. k simultaneous collisions produce k consecutive pulses in ascending index order. A slot can first reach PENDING no earlier than one cycle after its collision.
- slot_run = (state == ACTIVE), registered. slot_visible = (state == ACTIVE), registered, unless modified by the optional feature.
- pool_full is registered from next-state: high when no slot will be IDLE.
- Reset asserted mid-operation aborts all slots and any pending reports. Reports still queued are discarded.

Optional Feature:
PRESENT_BLINK_EN:
- Defined: while ACTIVE with timer <= BLINK_SEC, slot_visible[i] toggles on every sec_tick. The toggle register is forced to 1 on allocation. slot_run is unaffected.
- Undefined: slot_visible is steady high in ACTIVE and no blink logic is built.

Test Plan:
- Reset, then drop_req with type 2 -> drop_ack=1 and drop_slot=0 one cycle later; slot_visible=001 and slot_run=001.
- Three drops with types 1, 2, 3, then a fourth drop -> slots 0/1/2 allocated, pool_full=1, fourth drop gets no ack.
- Slot 0 active, 10 sec_ticks with no collision -> expire_pulse after the 10th tick, slot 0 IDLE, no collect_valid.
- Slots 0, 1, 2 active with types 1, 2, 3; col_rope=101 and col_player=010 in the same cycle -> three collect pulses on consecutive cycles: (slot 0, type 1), (slot 1, type 2), (slot 2, type 3).
- Slot 1 with timer=1 receives sec_tick and col_player[1] in the same cycle -> collected with type reported, no expire_pulse.
- With PRESENT_BLINK_EN and LIFE_SEC=10, BLINK_SEC=3 -> slot_visible steady for 7 ticks, then toggles on ticks 8 and 9, then the slot expires on tick 10.

Source files
------------

// File: rtl/present_pool_ctrl.sv
// rtl/present_pool_ctrl.sv - falling-present slot pool: allocate, time, collect and report slots
// Optional build macro PRESENT_BLINK_EN makes a slot blink once its remaining lifetime drops to BLINK_SEC.
module present_pool_ctrl #(
    parameter int NUM_SLOTS = 3,
    parameter int TYPE_W    = 2,
    parameter int LIFE_SEC  = 10,
    parameter int TIMER_W   = 4,
    parameter int BLINK_SEC = 3
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 drop_req,
    input  logic [TYPE_W-1:0]    drop_type,
    input  logic                 sec_tick,
    input  logic [NUM_SLOTS-1:0] col_player,
    input  logic [NUM_SLOTS-1:0] col_rope,
    output logic [NUM_SLOTS-1:0] slot_visible,
    output logic [NUM_SLOTS-1:0] slot_run,
    output logic                 drop_ack,
    output logic [2:0]           drop_slot,
    output logic                 pool_full,
    output logic                 collect_valid,
    output logic [TYPE_W-1:0]    collect_type,
    output logic [2:0]           collect_slot,
    output logic                 expire_pulse,
    output logic                 col_any
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_PENDING} slot_state_t;

    slot_state_t         r_state    [NUM_SLOTS];
    slot_state_t         w_state_nx [NUM_SLOTS];
    logic [TIMER_W-1:0]  r_timer    [NUM_SLOTS];
    logic [TIMER_W-1:0]  w_timer_nx [NUM_SLOTS];
    logic [TYPE_W-1:0]   r_type     [NUM_SLOTS];
    logic [TYPE_W-1:0]   w_type_nx  [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] w_hit;
    logic [NUM_SLOTS-1:0] w_expire;
    logic [NUM_SLOTS-1:0] w_active_nx;
    logic [NUM_SLOTS-1:0] w_vis_nx;
    logic                 w_full_nx;
    logic                 w_alloc;
    logic [2:0]           w_alloc_idx;
    logic                 w_pend_any;
    logic [2:0]           w_pend_idx;

    assign w_hit   = col_player | col_rope;
    assign col_any = |w_hit;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_alloc     = 1'b0;
        w_alloc_idx = '0;
        w_pend_any  = 1'b0;
        w_pend_idx  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_state[i] == S_IDLE) begin
                w_alloc     = drop_req;
                w_alloc_idx = 3'(i);
            end
            if (r_state[i] == S_PENDING) begin
                w_pend_any = 1'b1;
                w_pend_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= S_IDLE;
                r_timer[i] <= TIMER_W'(LIFE_SEC);
                r_type[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= w_state_nx[i];
                r_timer[i] <= w_timer_nx[i];
                r_type[i]  <= w_type_nx[i];
            end
        end
    end

    // A collision outranks a same-cycle expiry so the present is still collected.
    always_comb begin
        w_expire = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_state_nx[i] = r_state[i];
            w_timer_nx[i] = r_timer[i];
            w_type_nx[i]  = r_type[i];
            case (r_state[i])
                S_IDLE: begin
                    if (w_alloc && (w_alloc_idx == 3'(i))) begin
                        w_state_nx[i] = S_ACTIVE;
                        w_timer_nx[i] = TIMER_W'(LIFE_SEC);
                        w_type_nx[i]  = drop_type;
                    end
                end
                S_ACTIVE: begin
                    if (w_hit[i]) begin
                        w_state_nx[i] = S_PENDING;
                    end else if (sec_tick) begin
                        if (r_timer[i] == TIMER_W'(1)) begin
                            w_state_nx[i] = S_IDLE;
                            w_expire[i]   = 1'b1;
                        end else begin
                            w_timer_nx[i] = r_timer[i] - TIMER_W'(1);
                        end
                    end
                end
                S_PENDING: begin
                    if (w_pend_idx == 3'(i)) begin
                        w_state_nx[i] = S_IDLE;
                    end
                end
                default: w_state_nx[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_full_nx   = 1'b1;
        w_active_nx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_active_nx[i] = (w_state_nx[i] == S_ACTIVE);
            if (w_state_nx[i] == S_IDLE) begin
                w_full_nx = 1'b0;
            end
        end
    end

`ifdef PRESENT_BLINK_EN
    logic [NUM_SLOTS-1:0] r_blink;
    logic [NUM_SLOTS-1:0] w_blink_nx;

    always_comb begin
        w_blink_nx = r_blink;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if ((r_state[i] == S_IDLE) && (w_state_nx[i] == S_ACTIVE)) begin
                w_blink_nx[i] = 1'b1;
            end else if ((r_state[i] == S_ACTIVE) && sec_tick &&
                         (r_timer[i] <= TIMER_W'(BLINK_SEC))) begin
                w_blink_nx[i] = ~r_blink[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_blink <= '1;
        end else begin
            r_blink <= w_blink_nx;
        end
    end

    assign w_vis_nx = w_active_nx & w_blink_nx;
`else
    assign w_vis_nx = w_active_nx;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            slot_visible  <= '0;
            slot_run      <= '0;
            drop_ack      <= 1'b0;
            drop_slot     <= '0;
            pool_full     <= 1'b0;
            collect_valid <= 1'b0;
            collect_type  <= '0;
            collect_slot  <= '0;
            expire_pulse  <= 1'b0;
        end else begin
            slot_visible  <= w_vis_nx;
            slot_run      <= w_active_nx;
            drop_ack      <= w_alloc;
            drop_slot     <= w_alloc_idx;
            pool_full     <= w_full_nx;
            collect_valid <= w_pend_any;
            collect_type  <= r_type[w_pend_idx];
            collect_slot  <= w_pend_idx;
            expire_pulse  <= |w_expire;
        end
    end

endmodule

// File: tb/tb_present_pool_ctrl.sv
// tb/tb_present_pool_ctrl.sv - directed self-checking bench for present_pool_ctrl
module tb_present_pool_ctrl;

    logic       clk;
    logic       resetN;
    logic       drop_req;
    logic [1:0] drop_type;
    logic       sec_tick;
    logic [2:0] col_player;
    logic [2:0] col_rope;
    logic [2:0] slot_visible;
    logic [2:0] slot_run;
    logic       drop_ack;
    logic [2:0] drop_slot;
    logic       pool_full;
    logic       collect_valid;
    logic [1:0] collect_type;
    logic [2:0] collect_slot;
    logic       expire_pulse;
    logic       col_any;

    int checks = 0;
    int errors = 0;

    present_pool_ctrl #(
        .NUM_SLOTS(3), .TYPE_W(2), .LIFE_SEC(10), .TIMER_W(4), .BLINK_SEC(3)
    ) dut (
        .clk(clk), .resetN(resetN), .drop_req(drop_req), .drop_type(drop_type),
        .sec_tick(sec_tick), .col_player(col_player), .col_rope(col_rope),
        .slot_visible(slot_visible), .slot_run(slot_run), .drop_ack(drop_ack),
        .drop_slot(drop_slot), .pool_full(pool_full), .collect_valid(collect_valid),
        .collect_type(collect_type), .collect_slot(collect_slot),
        .expire_pulse(expire_pulse), .col_any(col_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0; drop_req = 1'b0; drop_type = '0; sec_tick = 1'b0;
        col_player = '0; col_rope = '0;
        step(); step();
        resetN = 1'b1;
        step();
    endtask

    task automatic drop(input logic [1:0] t);
        drop_req = 1'b1; drop_type = t;
        step();
        drop_req = 1'b0;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0; drop_req = 1'b0; drop_type = '0; sec_tick = 1'b0;
        col_player = '0; col_rope = '0;
        #2;
        checks++; if (slot_visible !== 3'b000) begin errors++; $display("FAIL reset_visible got %b exp 000", slot_visible); end
        checks++; if (slot_run !== 3'b000) begin errors++; $display("FAIL reset_run got %b exp 000", slot_run); end
        checks++; if (drop_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", drop_ack); end
        checks++; if (pool_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", pool_full); end
        checks++; if (collect_valid !== 1'b0) begin errors++; $display("FAIL reset_collect got %b exp 0", collect_valid); end
        checks++; if (expire_pulse !== 1'b0) begin errors++; $display("FAIL reset_expire got %b exp 0", expire_pulse); end
        checks++; if (col_any !== 1'b0) begin errors++; $display("FAIL reset_col_any got %b exp 0", col_any); end
        do_reset();
    endtask

    task automatic test_single_drop();
        do_reset();
        drop(2'd2);
        checks++; if (drop_ack !== 1'b1) begin errors++; $display("FAIL single_ack got %b exp 1", drop_ack); end
        checks++; if (drop_slot !== 3'd0) begin errors++; $display("FAIL single_slot got %0d exp 0", drop_slot); end
        checks++; if (slot_visible !== 3'b001) begin errors++; $display("FAIL single_visible got %b exp 001", slot_visible); end
        checks++; if (slot_run !== 3'b001) begin errors++; $display("FAIL single_run got %b exp 001", slot_run); end
        checks++; if (pool_full !== 1'b0) begin errors++; $display("FAIL single_full got %b exp 0", pool_full); end
        col_player = 3'b100;
        #1;
        checks++; if (col_any !== 1'b1) begin errors++; $display("FAIL single_col_any got %b exp 1", col_any); end
        step();
        col_player = '0;
        checks++; if (drop_ack !== 1'b0) begin errors++; $display("FAIL single_ack_pulse got %b exp 0", drop_ack); end
        step();
        checks++; if (collect_valid !== 1'b0) begin errors++; $display("FAIL idle_col_ignored got %b exp 0", collect_valid); end
        checks++; if (slot_run !== 3'b001) begin errors++; $display("FAIL idle_col_run got %b exp 001", slot_run); end
    endtask

    task automatic test_fill();
        do_reset();
        drop(2'd1);
        checks++; if (drop_slot !== 3'd0 || drop_ack !== 1'b1) begin errors++; $display("FAIL fill_slot0 got ack %b slot %0d exp 1/0", drop_ack, drop_slot); end
        drop(2'd2);
        checks++; if (drop_slot !== 3'd1 || drop_ack !== 1'b1) begin errors++; $display("FAIL fill_slot1 got ack %b slot %0d exp 1/1", drop_ack, drop_slot); end
        checks++; if (pool_full !== 1'b0) begin errors++; $display("FAIL fill_notfull got %b exp 0", pool_full); end
        drop(2'd3);
        checks++; if (drop_slot !== 3'd2 || drop_ack !== 1'b1) begin errors++; $display("FAIL fill_slot2 got ack %b slot %0d exp 1/2", drop_ack, drop_slot); end
        checks++; if (pool_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", pool_full); end
        checks++; if (slot_run !== 3'b111) begin errors++; $display("FAIL fill_run got %b exp 111", slot_run); end
        drop(2'd0);
        checks++; if (drop_ack !== 1'b0) begin errors++; $display("FAIL fill_fourth_ack got %b exp 0", drop_ack); end
        checks++; if (pool_full !== 1'b1) begin errors++; $display("FAIL fill_still_full got %b exp 1", pool_full); end
    endtask

    task automatic test_collect_order();
        col_rope = 3'b101; col_player = 3'b010;
        step();
        col_rope = '0; col_player = '0;
        checks++; if (collect_valid !== 1'b0) begin errors++; $display("FAIL order_early got %b exp 0", collect_valid); end
        checks++; if (slot_run !== 3'b000) begin errors++; $display("FAIL order_run got %b exp 000", slot_run); end
        step();
        checks++; if (collect_valid !== 1'b1 || collect_slot !== 3'd0 || collect_type !== 2'd1) begin errors++; $display("FAIL order_p0 got v%b s%0d t%0d exp v1 s0 t1", collect_valid, collect_slot, collect_type); end
        step();
        checks++; if (collect_valid !== 1'b1 || collect_slot !== 3'd1 || collect_type !== 2'd2) begin errors++; $display("FAIL order_p1 got v%b s%0d t%0d exp v1 s1 t2", collect_valid, collect_slot, collect_type); end
        step();
        checks++; if (collect_valid !== 1'b1 || collect_slot !== 3'd2 || collect_type !== 2'd3) begin errors++; $display("FAIL order_p2 got v%b s%0d t%0d exp v1 s2 t3", collect_valid, collect_slot, collect_type); end
        checks++; if (pool_full !== 1'b0) begin errors++; $display("FAIL order_full got %b exp 0", pool_full); end
        step();
        checks++; if (collect_valid !== 1'b0) begin errors++; $display("FAIL order_end got %b exp 0", collect_valid); end
    endtask

    task automatic test_expire();
        do_reset();
        drop(2'd1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            step();
        end
        checks++; if (slot_run !== 3'b001 || expire_pulse !== 1'b0) begin errors++; $display("FAIL expire_tick9 got run %b exp_p %b exp 001/0", slot_run, expire_pulse); end
        tick();
        checks++; if (expire_pulse !== 1'b1) begin errors++; $display("FAIL expire_pulse got %b exp 1", expire_pulse); end
        checks++; if (slot_run !== 3'b000 || slot_visible !== 3'b000) begin errors++; $display("FAIL expire_idle got run %b vis %b exp 000", slot_run, slot_visible); end
        checks++; if (collect_valid !== 1'b0) begin errors++; $display("FAIL expire_nocollect got %b exp 0", collect_valid); end
        step();
        checks++; if (expire_pulse !== 1'b0 || collect_valid !== 1'b0) begin errors++; $display("FAIL expire_after got %b/%b exp 0/0", expire_pulse, collect_valid); end
        drop(2'd3);
        checks++; if (drop_ack !== 1'b1 || drop_slot !== 3'd0) begin errors++; $display("FAIL expire_realloc got ack %b slot %0d exp 1/0", drop_ack, drop_slot); end
    endtask

    task automatic test_col_beats_expire();
        do_reset();
        drop(2'd1);
        drop(2'd2);
        col_rope = 3'b001;
        step();
        col_rope = '0;
        step();
        step();
        checks++; if (slot_run !== 3'b010) begin errors++; $display("FAIL cbe_setup got %b exp 010", slot_run); end
        for (int k = 1; k <= 9; k++) tick();
        sec_tick = 1'b1; col_player = 3'b010;
        step();
        sec_tick = 1'b0; col_player = '0;
        checks++; if (expire_pulse !== 1'b0) begin errors++; $display("FAIL cbe_noexpire got %b exp 0", expire_pulse); end
        checks++; if (slot_run !== 3'b000) begin errors++; $display("FAIL cbe_run got %b exp 000", slot_run); end
        step();
        checks++; if (collect_valid !== 1'b1 || collect_slot !== 3'd1 || collect_type !== 2'd2) begin errors++; $display("FAIL cbe_collect got v%b s%0d t%0d exp v1 s1 t2", collect_valid, collect_slot, collect_type); end
        checks++; if (expire_pulse !== 1'b0) begin errors++; $display("FAIL cbe_noexpire2 got %b exp 0", expire_pulse); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drop(2'd1); drop(2'd2); drop(2'd3);
        col_player = 3'b001;
        step();
        col_player = '0;
        drop_req = 1'b1; drop_type = 2'd0;
        step();
        checks++; if (drop_ack !== 1'b0) begin errors++; $display("FAIL b2b_no_reuse got %b exp 0", drop_ack); end
        checks++; if (collect_valid !== 1'b1 || collect_slot !== 3'd0) begin errors++; $display("FAIL b2b_collect got v%b s%0d exp v1 s0", collect_valid, collect_slot); end
        step();
        drop_req = 1'b0;
        checks++; if (drop_ack !== 1'b1 || drop_slot !== 3'd0) begin errors++; $display("FAIL b2b_reuse got ack %b slot %0d exp 1/0", drop_ack, drop_slot); end
        checks++; if (pool_full !== 1'b1) begin errors++; $display("FAIL b2b_full got %b exp 1", pool_full); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drop(2'd1); drop(2'd2); drop(2'd3);
        col_rope = 3'b111;
        step();
        col_rope = '0;
        step();
        resetN = 1'b0;
        #1;
        checks++; if (collect_valid !== 1'b0 || slot_run !== 3'b000 || pool_full !== 1'b0) begin errors++; $display("FAIL mid_reset got v%b run %b full %b exp 0/000/0", collect_valid, slot_run, pool_full); end
        step();
        resetN = 1'b1;
        step(); step();
        checks++; if (collect_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_discard got %b exp 0", collect_valid); end
    endtask

`ifdef PRESENT_BLINK_EN
    task automatic test_blink();
        logic [2:0] exp_vis;
        do_reset();
        drop(2'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_vis = (k <= 7 || k == 9) ? 3'b001 : 3'b000;
            checks++; if (slot_visible !== exp_vis) begin errors++; $display("FAIL blink_tick%0d got %b exp %b", k, slot_visible, exp_vis); end
            checks++; if (k < 10 && slot_run !== 3'b001) begin errors++; $display("FAIL blink_run%0d got %b exp 001", k, slot_run); end
        end
        checks++; if (expire_pulse !== 1'b1) begin errors++; $display("FAIL blink_expire got %b exp 1", expire_pulse); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_drop();
        test_fill();
        test_collect_order();
        test_expire();
        test_col_beats_expire();
        test_back_to_back();
        test_reset_mid();
`ifdef PRESENT_BLINK_EN
        test_blink();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
